// File: rtl/quad_step_decoder.sv
// Quadrature A/B decoder: 2-flop sync, stability filter, Gray decode to step strobes, wrapping position, sticky err.
// Latency: 2+FILTER clk edges from the first sample of a new A/B value to the registered outputs.
// Backpressure: none; encoder motion faster than one step per FILTER+1 cycles skips states and raises err.
module quad_step_decoder #(
   parameter int WIDTH  = 4,
   parameter int FILTER = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a_in,
   input  logic             b_in,
   input  logic             clear,
   output logic             step_en,
   output logic             step_up,
   output logic [WIDTH-1:0] position,
   output logic             wrap,
   output logic             err
);

   localparam logic [4:0]       LP_FILTER = 5'(FILTER);
   localparam logic [WIDTH-1:0] LP_ONE    = WIDTH'(1);
   localparam logic [WIDTH-1:0] LP_MAX    = '1;

   // Gray position of an {A,B} pair along the forward sequence 00,01,11,10
   function automatic logic [1:0] f_gray_idx(input logic [1:0] i_ab);
      f_gray_idx = {i_ab[1], i_ab[1] ^ i_ab[0]};
   endfunction

   logic             r_a_s1, r_a_s2, r_b_s1, r_b_s2;
   logic [1:0]       r_cand;
   logic [3:0]       r_cnt;
   logic [1:0]       r_filt;
   logic             r_init;
   logic             r_step_en, r_step_up, r_wrap, r_err;
   logic [WIDTH-1:0] r_pos;

   logic [1:0]       w_pair;
   logic [1:0]       w_cand_nxt;
   logic [3:0]       w_cnt_nxt;
   logic             w_accept;
   logic [1:0]       w_delta;
   logic             w_fwd, w_rev, w_ill;
   logic [WIDTH-1:0] w_pos_nxt;
   logic             w_wrap_nxt;

   assign w_pair = {r_a_s2, r_b_s2};

   // Two-flop synchronizers for the asynchronous encoder phases
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_a_s1 <= 1'b0;
         r_a_s2 <= 1'b0;
         r_b_s1 <= 1'b0;
         r_b_s2 <= 1'b0;
      end else begin
         r_a_s1 <= a_in;
         r_a_s2 <= r_a_s1;
         r_b_s1 <= b_in;
         r_b_s2 <= r_b_s1;
      end
   end

   // Filter next state: reload on change, else count stable cycles; accept once the
   // synchronized pair has been seen FILTER edges in a row (including this one)
   always_comb begin
      w_cand_nxt = r_cand;
      w_cnt_nxt  = r_cnt;
      if (w_pair != r_cand) begin
         w_cand_nxt = w_pair;
         w_cnt_nxt  = 4'd0;
      end else if (r_cnt != 4'hF) begin
         w_cnt_nxt  = r_cnt + 4'd1;
      end
      w_accept = (({1'b0, w_cnt_nxt} + 5'd1) >= LP_FILTER) && (w_cand_nxt != r_filt);
   end

   // Decode the accepted transition; the first accepted state after reset only primes r_filt
   always_comb begin
      w_delta    = f_gray_idx(w_cand_nxt) - f_gray_idx(r_filt);
      w_fwd      = w_accept && r_init && (w_delta == 2'd1);
      w_rev      = w_accept && r_init && (w_delta == 2'd3);
      w_ill      = w_accept && r_init && (w_delta == 2'd2);
      w_pos_nxt  = r_pos;
      if (clear)
         w_pos_nxt = '0;
      else if (w_fwd)
         w_pos_nxt = r_pos + LP_ONE;
      else if (w_rev)
         w_pos_nxt = r_pos - LP_ONE;
      w_wrap_nxt = !clear && ((w_fwd && (r_pos == LP_MAX)) || (w_rev && (r_pos == '0)));
   end

   // Filter and decode state registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cand <= 2'b00;
         r_cnt  <= 4'd0;
         r_filt <= 2'b00;
         r_init <= 1'b0;
      end else begin
         r_cand <= w_cand_nxt;
         r_cnt  <= w_cnt_nxt;
         if (w_accept) begin
            r_filt <= w_cand_nxt;
            r_init <= 1'b1;
         end
      end
   end

   // Registered outputs; clear wins over a same-cycle step or illegal transition
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_step_en <= 1'b0;
         r_step_up <= 1'b0;
         r_pos     <= '0;
         r_wrap    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_step_en <= w_fwd || w_rev;
         if (w_fwd || w_rev)
            r_step_up <= w_fwd;
         r_pos  <= w_pos_nxt;
         r_wrap <= w_wrap_nxt;
         if (clear)
            r_err <= 1'b0;
         else if (w_ill)
            r_err <= 1'b1;
      end
   end

   assign step_en  = r_step_en;
   assign step_up  = r_step_up;
   assign position = r_pos;
   assign wrap     = r_wrap;
   assign err      = r_err;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: table of encoder moves with expected outputs, scoreboarded by due cycle.
// Expected outputs land 2+FILTER edges after each move is driven; any other cycle must show no strobes.
// Hand sequences cover reset/init, idle clear, glitch rejection, clear collision and a 3-cycle hold.
module tb_quad_step_decoder;

   localparam int FILTER = 2;
   localparam int WIDTH  = 4;
   localparam int LAT    = 2 + FILTER;
   localparam int NVEC   = 28;

   logic             clk, rst, a_in, b_in, clear;
   logic             step_en, step_up, wrap, err;
   logic [WIDTH-1:0] position;

   quad_step_decoder #(.WIDTH(WIDTH), .FILTER(FILTER)) dut (
      .clk      (clk),
      .rst      (rst),
      .a_in     (a_in),
      .b_in     (b_in),
      .clear    (clear),
      .step_en  (step_en),
      .step_up  (step_up),
      .position (position),
      .wrap     (wrap),
      .err      (err)
   );

   typedef struct {
      logic [1:0] ab;
      logic       en;
      logic       up;
      logic [3:0] pos;
      logic       wr;
      logic       er;
   } vec_t;

   typedef struct {
      int         due;
      logic [7:0] exp;
      int         id;
   } sb_t;

   vec_t       tbl [NVEC];
   sb_t        sbq [$];
   sb_t        mon_e;
   int         checks = 0;
   int         errors = 0;
   int         cyc    = 0;
   logic [7:0] obs;

   assign obs = {step_en, step_up, position, wrap, err};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: compare every due expectation; otherwise no strobe may appear
   always @(negedge clk) begin
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
         mon_e = sbq.pop_front();
         checks++;
         if (obs !== mon_e.exp) begin
            errors++;
            $display("FAIL step%0d {en,up,pos,wrap,err} got %b want %b at cycle %0d",
                     mon_e.id, obs, mon_e.exp, cyc);
         end
      end else if (rst) begin
         checks++;
         if (step_en !== 1'b0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL idle_strobe step_en=%b wrap=%b want 0 0 at cycle %0d", step_en, wrap, cyc);
         end
      end
   end

   function automatic vec_t mkv(input logic [1:0] ab, input logic en, input logic up,
                                input logic [3:0] pos, input logic wr, input logic er);
      vec_t v;
      v.ab = ab; v.en = en; v.up = up; v.pos = pos; v.wr = wr; v.er = er;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s {en,up,pos,wrap,err} got %b want %b", nm, act, exp);
      end
   endtask

   task automatic push(input logic [7:0] exp, input int id);
      sb_t e;
      e.due = cyc + LAT;
      e.exp = exp;
      e.id  = id;
      sbq.push_back(e);
   endtask

   task automatic apply(input int i);
      {a_in, b_in} = tbl[i].ab;
      push({tbl[i].en, tbl[i].up, tbl[i].pos, tbl[i].wr, tbl[i].er}, i);
      repeat (6) @(negedge clk);
   endtask

   initial begin
      logic [1:0] fwd [4];
      fwd = '{2'b01, 2'b11, 2'b10, 2'b00};

      // Filtered state starts at 11 after the init load, position 0
      tbl[0] = mkv(2'b01, 1'b1, 1'b0, 4'd15, 1'b1, 1'b0);
      tbl[1] = mkv(2'b00, 1'b1, 1'b0, 4'd14, 1'b0, 1'b0);
      // Idle clear brings position back to 0, then sixteen forward steps
      for (int k = 0; k < 16; k++)
         tbl[2 + k] = mkv(fwd[k % 4], 1'b1, 1'b1, 4'((k + 1) % 16), (k == 15), 1'b0);
      tbl[18] = mkv(2'b10, 1'b1, 1'b0, 4'd15, 1'b1, 1'b0);  // reverse from zero
      tbl[19] = mkv(2'b00, 1'b1, 1'b1, 4'd0,  1'b1, 1'b0);  // forward 15 -> 0
      tbl[20] = mkv(2'b11, 1'b0, 1'b1, 4'd0,  1'b0, 1'b1);  // illegal 00 -> 11
      tbl[21] = mkv(2'b10, 1'b1, 1'b1, 4'd1,  1'b0, 1'b1);  // legal after illegal, err sticky
      tbl[22] = mkv(2'b00, 1'b1, 1'b1, 4'd2,  1'b0, 1'b1);
      tbl[23] = mkv(2'b01, 1'b1, 1'b1, 4'd3,  1'b0, 1'b1);
      tbl[24] = mkv(2'b11, 1'b1, 1'b1, 4'd4,  1'b0, 1'b1);
      tbl[25] = mkv(2'b10, 1'b1, 1'b1, 4'd5,  1'b0, 1'b1);
      tbl[26] = mkv(2'b00, 1'b1, 1'b1, 4'd6,  1'b0, 1'b1);
      tbl[27] = mkv(2'b01, 1'b1, 1'b1, 4'd7,  1'b0, 1'b1);

      rst = 1'b0; a_in = 1'b1; b_in = 1'b1; clear = 1'b0;

      // Reset with the encoder resting at 11
      repeat (3) begin
         @(negedge clk);
         chk("reset_outputs", obs, 8'h00);
      end
      rst = 1'b1;
      repeat (LAT + 2) @(negedge clk);
      chk("init_no_event", obs, 8'h00);

      apply(0);
      apply(1);

      // Idle clear: no step, position and err zeroed
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      @(negedge clk);
      chk("idle_clear", obs, 8'h00);

      for (int i = 2; i < NVEC; i++) apply(i);

      // One-cycle glitch 01 -> 11 -> 01 must be ignored
      a_in = 1'b1;
      @(negedge clk);
      a_in = 1'b0;
      repeat (8) @(negedge clk);
      chk("glitch_hold", obs, {1'b0, 1'b1, 4'd7, 1'b0, 1'b1});

      // Up step at position 7 accepted in the same cycle as clear
      {a_in, b_in} = 2'b11;
      push({1'b1, 1'b1, 4'd0, 1'b0, 1'b0}, 100);
      repeat (LAT - 1) @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      repeat (5) @(negedge clk);

      // Three-cycle hold is accepted, then the return is a reverse step
      {a_in, b_in} = 2'b10;
      push({1'b1, 1'b1, 4'd1, 1'b0, 1'b0}, 101);
      repeat (3) @(negedge clk);
      {a_in, b_in} = 2'b11;
      push({1'b1, 1'b0, 4'd0, 1'b0, 1'b0}, 102);

      for (int t = 0; t < 50 && sbq.size() > 0; t++) @(negedge clk);
      if (sbq.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain %0d expectations still pending, want 0", sbq.size());
      end
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
